// File: rtl/adc_frame_averager.sv
// Frame averager for ADC samples: accumulates 2^LOG2_N samples, emits the
// floor mean minus OFFSET as a signed value, and drops frames hit by ADC errors.
module adc_frame_averager #(
    parameter int DATA_W = 12,
    parameter int LOG2_N = 4,
    parameter int OFFSET = 2048
) (
    input  logic                     sck,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     valid_i,
    input  logic                     error_i,
    input  logic                     clear_i,
    output logic signed [DATA_W:0]   avg_o,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic [7:0]               drop_cnt_o
);

    localparam int                ACC_W  = DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST   = '1;
    localparam logic [DATA_W:0]   OFF_C  = (DATA_W + 1)'(OFFSET);

    logic [ACC_W-1:0]  r_acc;
    logic [LOG2_N-1:0] r_cnt;
    logic [DATA_W:0]   r_avg;
    logic              r_valid;
    logic              r_busy;
    logic [7:0]        r_drop;

    logic [ACC_W-1:0]  w_total;
    logic [DATA_W-1:0] w_mean;
    logic [DATA_W:0]   w_avg;

    // Accumulator is wide enough that the full-frame sum never overflows.
    always_comb begin
        w_total = r_acc + ACC_W'(data_i);
        w_mean  = DATA_W'(w_total >> LOG2_N);
        w_avg   = {1'b0, w_mean} - OFF_C;
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_avg   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_drop  <= '0;
        end else if (clear_i) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_drop  <= '0;
        end else if (error_i) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            if (r_drop != 8'hFF)
                r_drop <= r_drop + 8'd1;
        end else if (valid_i && (r_cnt != LAST)) begin
            r_acc   <= w_total;
            r_cnt   <= r_cnt + 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
        end else if (valid_i) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_avg   <= w_avg;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign avg_o      = $signed(r_avg);
    assign valid_o    = r_valid;
    assign busy_o     = r_busy;
    assign drop_cnt_o = r_drop;

endmodule

// File: doc/adc_frame_averager.md
Name: adc_frame_averager

Overview:
- Sits directly downstream of the ADC serial interface, in the same `sck` domain.
- Consumes each 12-bit sample together with its valid and error strobes.
- Averages non-overlapping frames of 2^LOG2_N samples and emits one offset-corrected signed average per frame.
- Discards any frame corrupted by an ADC error and counts the discards for status readout.

Parameters:
- DATA_W, 12: width of the incoming unsigned ADC sample.
- LOG2_N, 4: log2 of samples per frame; N = 16 by default; legal range 1..8.
- OFFSET, 2048: mid-scale code subtracted from the frame mean to produce the signed output.

Ports:
- sck  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_i  in  DATA_W  unsigned ADC sample; sampled only when valid_i=1.
- valid_i  in  1  one-cycle strobe marking data_i as a new sample.
- error_i  in  1  one-cycle ADC framing-error strobe.
- clear_i  in  1  synchronous restart; clears the partial frame and drop_cnt_o.
- avg_o  out  DATA_W+1  signed result: floor(frame sum / N) - OFFSET.
- valid_o  out  1  one-cycle pulse; avg_o is valid on this cycle.
- busy_o  out  1  high while a partial frame is held (sample count != 0).
- drop_cnt_o  out  8  saturating count of error events.

Behaviour:
- Reset: rst_n=0 asynchronously forces the following, and they hold until the first rising edge with rst_n=1:
  - acc = 0 (width DATA_W+LOG2_N) and cnt = 0 (width LOG2_N);
  - avg_o = 0, valid_o = 0, busy_o = 0, drop_cnt_o = 0.
- State is the sample counter cnt:
  - cnt = 0 is EMPTY;
  - cnt = 1..N-1 is FILLING.
  - Transitions below are evaluated per rising edge, in priority order.
- 1) clear_i=1:
  - acc=0, cnt=0, drop_cnt_o=0, valid_o=0.
  - valid_i and error_i are ignored that cycle.
- 2) error_i=1:
  - acc=0, cnt=0, valid_o=0.
  - drop_cnt_o increments, saturating at 255.
  - A valid_i on the same cycle is discarded, including a frame-completing sample; no output is produced.
- 3) valid_i=1 with cnt < N-1:
  - acc += data_i, cnt += 1, valid_o=0.
- 4) valid_i=1 with cnt = N-1 (frame complete):
  - total = acc + data_i, computed at full width with no overflow because acc is DATA_W+LOG2_N bits.
  - avg_o is registered as (total >> LOG2_N) - OFFSET, computed signed in DATA_W+1 bits; truncation is floor, with no rounding.
  - valid_o=1 for exactly this one registered cycle.
  - acc=0, cnt=0.
- 5) Otherwise: hold acc and cnt; valid_o=0.
- Latency: valid_o is asserted on the clock edge that captures the Nth accepted sample, i.e. the register output is high in the cycle after the Nth valid_i strobe.
- avg_o holds its last value between valid_o pulses and is not cleared by clear_i.
- Back-to-back samples:
  - valid_i may be high on consecutive cycles;
  - a sample arriving in the cycle where valid_o is high belongs to the next frame;
  - no samples are lost at frame boundaries.
- busy_o = (cnt != 0), registered alongside cnt.
- Gaps of any length between valid_i strobes are allowed; there is no timeout.
- Reset asserted mid-frame: the partial frame is lost silently and drop_cnt_o is not incremented.

Test Plan:
- Reset then 16 valid_i strobes of data_i=12'h48F -> exactly one valid_o pulse, 1 cycle after the 16th strobe, with avg_o = 1167-2048 = -881; busy_o falls on the same edge.
- 16 samples 2040..2055 -> sum 32760, floor(2047.5)=2047, avg_o=-1 (truncation, not rounding).
- 16 samples of 12'hFFF, then 16 of 12'h000, all back-to-back -> avg_o=2047, then -2048; two valid_o pulses 16 cycles apart; no sample lost.
- 10 samples, then error_i, then 16 samples of 12'h800 -> drop_cnt_o=1; a single valid_o pulse with avg_o=0; the errored partial frame contributes nothing.
- error_i coincident with the 16th valid_i -> no valid_o, drop_cnt_o increments, busy_o=0.
- 300 error_i pulses -> drop_cnt_o saturates at 255; clear_i -> 0.
- rst_n low mid-frame (cnt=7) -> all outputs 0 immediately, without waiting for a clock edge; the next 16 samples form a fresh frame.
